// File: rtl/vec_sweep_ctrl.sv
// Exhaustive input sweeper for small combinational units: drives every
// input vector in ascending order, captures settled outputs, folds a signature.
module vec_sweep_ctrl #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 3,
  parameter int DWELL = 3,
  parameter int SIG_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [N_IN-1:0]  dut_in,
  input  logic [N_OUT-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic [N_IN-1:0]  vec_idx,
  input  logic [N_IN-1:0]  rd_addr,
  output logic [N_OUT-1:0] rd_data,
  output logic [SIG_W-1:0] sig
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    DONE
  } state_t;

  localparam int CW = 8;
  localparam int DEPTH = 1 << N_IN;
  localparam logic [CW-1:0] CNT_END = CW'(DWELL - 1);
  localparam logic [N_IN-1:0] LAST = '1;

  state_t state;
  state_t state_n;
  logic [CW-1:0] cnt;
  logic [N_OUT-1:0] mem [DEPTH];
  logic cap_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (abort) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE, DONE: if (start) state_n = SETTLE;
        SETTLE:     if (cnt == CNT_END) state_n = CAPTURE;
        CAPTURE:    state_n = (vec_idx == LAST) ? DONE : SETTLE;
        default:    state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state == SETTLE) || (state == CAPTURE);
    done = (state == DONE);
  end

  // abort wins over a capture landing on the same edge
  assign cap_en = (state == CAPTURE) && !abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dut_in  <= '0;
      vec_idx <= '0;
      cnt     <= '0;
      sig     <= '0;
    end else if (abort) begin
      dut_in  <= '0;
      vec_idx <= '0;
      cnt     <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            dut_in  <= '0;
            vec_idx <= '0;
            cnt     <= '0;
            sig     <= '0;
          end
        end
        SETTLE: begin
          if (cnt != CNT_END) cnt <= cnt + 1'b1;
        end
        CAPTURE: begin
          sig <= {sig[SIG_W-2:0], sig[SIG_W-1]}
               ^ SIG_W'({vec_idx, dut_out});
          if (vec_idx != LAST) begin
            vec_idx <= vec_idx + 1'b1;
            dut_in  <= vec_idx + 1'b1;
            cnt     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // read-before-write: a same-cycle read of the written entry sees old data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      rd_data <= mem[rd_addr];
      if (cap_en) mem[vec_idx] <= dut_out;
    end
  end

endmodule

// File: tb/tb_vec_sweep_ctrl.sv
// Directed bench for vec_sweep_ctrl at DWELL=3 and DWELL=1,
// driving a 4-in/3-out logic unit model.
module tb_vec_sweep_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic start1 = 1'b0;
  logic [3:0] rd_addr = '0;
  logic [3:0] rd_addr1 = '0;
  logic [3:0] dut_in, vec_idx, dut_in1, vec_idx1;
  logic [2:0] dut_out, rd_data, dut_out1, rd_data1;
  logic busy, done, busy1, done1;
  logic [15:0] sig, sig1;
  int n_chk = 0;
  int n_fail = 0;

  // Out1=A&B, Out2=C|D, Out3=A^B^C^D with A the MSB
  function automatic logic [2:0] unit(logic [3:0] v);
    return {v[3] & v[2], v[1] | v[0], ^v};
  endfunction

  function automatic logic [15:0] fold(int last);
    logic [15:0] s;
    s = '0;
    for (int v = 0; v <= last; v++)
      s = {s[14:0], s[15]} ^ {9'b0, 4'(v), unit(4'(v))};
    return s;
  endfunction

  assign dut_out  = unit(dut_in);
  assign dut_out1 = unit(dut_in1);

  always #5 clk = ~clk;

  vec_sweep_ctrl u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done),
    .vec_idx(vec_idx), .rd_addr(rd_addr), .rd_data(rd_data), .sig(sig)
  );

  vec_sweep_ctrl #(.DWELL(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(1'b0),
    .dut_in(dut_in1), .dut_out(dut_out1), .busy(busy1), .done(done1),
    .vec_idx(vec_idx1), .rd_addr(rd_addr1), .rd_data(rd_data1), .sig(sig1)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] spot_exp [4];
  logic [3:0] spot_adr [4];
  int n;
  int seen;

  initial begin
    spot_adr[0] = 4'd0;  spot_exp[0] = 3'b000;
    spot_adr[1] = 4'd5;  spot_exp[1] = 3'b010;
    spot_adr[2] = 4'd12; spot_exp[2] = 3'b100;
    spot_adr[3] = 4'd15; spot_exp[3] = 3'b110;

    // reset state
    #1 rst = 1'b1;
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dut_in", dut_in, 0);
    check("rst_vec_idx", vec_idx, 0);
    check("rst_sig", sig, 0);
    check("rst_rd_data", rd_data, 0);
    step();
    rst = 1'b0;
    step();

    // async reset mid-sweep
    start = 1'b1; step(); start = 1'b0;
    for (int e = 1; e <= 20; e++) step();
    check("mid_busy", busy, 1);
    check("mid_dut_in", dut_in, 5);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_dut_in", dut_in, 0);
    check("arst_vec_idx", vec_idx, 0);
    check("arst_sig", sig, 0);
    #1 rst = 1'b0;
    step();
    check("arst_idle", busy, 0);

    // full sweep, with a stray start at cycle 10
    start = 1'b1; step(); start = 1'b0;
    check("sw0_dut_in", dut_in, 0);
    check("sw0_busy", busy, 1);
    for (int e = 1; e <= 64; e++) begin
      start = (e == 10);
      step();
      check("sw_dut_in", dut_in, (e < 64) ? e / 4 : 15);
      check("sw_vec_idx", vec_idx, (e < 64) ? e / 4 : 15);
      check("sw_busy", busy, (e < 64) ? 1 : 0);
      check("sw_done", done, (e == 64) ? 1 : 0);
    end
    start = 1'b0;
    check("sw_sig", sig, fold(15));
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a); step();
      check("sw_mem", rd_data, unit(4'(a)));
    end
    for (int k = 0; k < 4; k++) begin
      rd_addr = spot_adr[k]; step();
      check("sw_mem_spot", rd_data, spot_exp[k]);
    end
    check("sw_done_held", done, 1);

    // restart from DONE
    start = 1'b1; step(); start = 1'b0;
    check("rs_done_drop", done, 0);
    check("rs_busy", busy, 1);
    check("rs_sig_clr", sig, 0);
    n = 0;
    while (!done && n < 200) begin step(); n++; end
    check("rs_cycles", n, 64);
    check("rs_sig", sig, fold(15));

    // abort during vector 6, on a cleared buffer
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    step();
    start = 1'b1; step(); start = 1'b0;
    for (int e = 1; e <= 25; e++) begin
      abort = (e == 25);
      step();
    end
    abort = 1'b0;
    check("ab_busy", busy, 0);
    check("ab_done", done, 0);
    check("ab_dut_in", dut_in, 0);
    check("ab_vec_idx", vec_idx, 0);
    check("ab_sig", sig, fold(5));
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a); step();
      check("ab_mem", rd_data, (a < 6) ? unit(4'(a)) : 3'b000);
    end
    seen = 0;
    for (int e = 0; e < 70; e++) begin
      step();
      if (done || busy) seen++;
    end
    check("ab_stay_idle", seen, 0);

    // start and abort together
    start = 1'b1; abort = 1'b1; step();
    start = 1'b0; abort = 1'b0;
    check("sa_busy", busy, 0);
    step();
    check("sa_busy2", busy, 0);
    check("sa_dut_in", dut_in, 0);

    // DWELL=1 build
    start1 = 1'b1; step(); start1 = 1'b0;
    check("d1_busy", busy1, 1);
    n = 0;
    while (!done1 && n < 200) begin step(); n++; end
    check("d1_cycles", n, 32);
    check("d1_dut_in", dut_in1, 15);
    check("d1_sig", sig1, fold(15));
    for (int a = 0; a < 16; a++) begin
      rd_addr1 = 4'(a); step();
      check("d1_mem", rd_data1, unit(4'(a)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
